// File: rtl/rewind_walker_pkg.sv
// Shared rewind/ROB definitions: default geometry, index types and walker states.
`ifndef WAY
`define WAY 3
`endif
`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif

package rewind_walker_pkg;
    localparam int WAY_DEF      = `WAY;
    localparam int ROB_SIZE_DEF = `ROB_SIZE;
    localparam int PR_W_DEF     = 6;
    localparam int ROB_IDX_W    = $clog2(ROB_SIZE_DEF);

    typedef logic [ROB_IDX_W-1:0] rob_idx_t;
    typedef logic [PR_W_DEF-1:0]  phy_reg_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        FIN  = 2'd2
    } walk_state_e;
endpackage

// File: rtl/rewind_walker_if.sv
// Rewind bundle from the walker to the freelist side.
interface rewind_if #(
    parameter int WAY   = 3,
    parameter int IDX_W = 5,
    parameter int PR_W  = 6,
    parameter int NUM_W = 3
);
    logic [NUM_W-1:0]         num;
    logic [WAY-1:0][PR_W-1:0] reg_T;
    logic                     busy;
    logic                     done;
    logic [IDX_W-1:0]         new_tail;

    modport walker   (output num, reg_T, busy, done, new_tail);
    modport freelist (input  num, reg_T, busy, done, new_tail);
endinterface

// File: rtl/rewind_walker_rob_idx_sub.sv
// Modular ROB index subtraction; wrap comes for free from the power-of-two width.
module rob_idx_sub #(
    parameter int IDX_W = 5
) (
    input  logic [IDX_W-1:0] i_a,
    input  logic [IDX_W-1:0] i_b,
    output logic [IDX_W-1:0] o_diff
);
    assign o_diff = i_a - i_b;
endmodule

// File: rtl/rewind_walker.sv
// Mispredict rewind walker: walks the squashed ROB entries youngest-group-first,
// returning up to WAY destination tags per cycle, then pulses done with the new tail.
module rewind_walker
    import rewind_walker_pkg::*;
#(
    parameter  int WAY      = WAY_DEF,
    parameter  int ROB_SIZE = ROB_SIZE_DEF,
    parameter  int PR_W     = PR_W_DEF,
    localparam int IDX_W    = $clog2(ROB_SIZE),
    localparam int NUM_W    = $clog2(WAY) + 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      mispredict_valid,
    input  logic [IDX_W-1:0]          branch_idx,
    input  logic [IDX_W-1:0]          rob_tail,
    output logic [WAY-1:0][IDX_W-1:0] rob_rd_idx,
    input  logic [WAY-1:0][PR_W-1:0]  rob_rd_T,
    output logic [NUM_W-1:0]          rewind_num,
    output logic [WAY-1:0][PR_W-1:0]  rewind_reg_T,
    output logic                      busy,
    output logic                      done,
    output logic [IDX_W-1:0]          new_tail
);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [IDX_W-1:0] WAY_IDX = IDX_W'(WAY);

    walk_state_e              r_state;
    walk_state_e              w_state_nxt;
    logic [IDX_W-1:0]         r_ptr;
    logic [IDX_W-1:0]         r_rem;
    logic [IDX_W-1:0]         r_branch;
    logic [IDX_W-1:0]         w_ptr_init;
    logic [IDX_W-1:0]         w_rem_init;
    logic [IDX_W-1:0]         w_ptr_step;
    logic [IDX_W-1:0]         w_rem_step;
    logic [IDX_W-1:0]         w_n;
    logic                     w_start;
    logic [WAY-1:0][PR_W-1:0] w_reg_T;

    rewind_if #(.WAY(WAY), .IDX_W(IDX_W), .PR_W(PR_W), .NUM_W(NUM_W)) u_rw_if ();

    // Youngest squashed entry sits just below the tail; count excludes the branch itself.
    rob_idx_sub #(.IDX_W(IDX_W)) u_ptr_init (.i_a(rob_tail),   .i_b(IDX_ONE),    .o_diff(w_ptr_init));
    rob_idx_sub #(.IDX_W(IDX_W)) u_rem_init (.i_a(w_ptr_init), .i_b(branch_idx), .o_diff(w_rem_init));
    rob_idx_sub #(.IDX_W(IDX_W)) u_ptr_step (.i_a(r_ptr),      .i_b(w_n),        .o_diff(w_ptr_step));

    assign w_rem_step = r_rem - w_n;
    assign w_start    = (r_state == IDLE) && mispredict_valid;

    // Group size for this cycle: min(WAY, remaining) while walking, else nothing.
    always_comb begin
        w_n = '0;
        if (r_state == WALK) begin
            if (r_rem > WAY_IDX) begin
                w_n = WAY_IDX;
            end else begin
                w_n = r_rem;
            end
        end else begin
            w_n = '0;
        end
    end

    // Slot g addresses ptr-(n-1-g) so slot 0 is the oldest of the group.
    for (genvar g = 0; g < WAY; g++) begin : g_slot
        logic             w_use;
        logic [IDX_W-1:0] w_back;
        logic [IDX_W-1:0] w_addr;

        assign w_use  = (IDX_W'(g) < w_n);
        assign w_back = w_n - IDX_ONE - IDX_W'(g);

        rob_idx_sub #(.IDX_W(IDX_W)) u_addr (.i_a(r_ptr), .i_b(w_back), .o_diff(w_addr));

        assign rob_rd_idx[g] = w_use ? w_addr : '0;
        assign w_reg_T[g]    = w_use ? rob_rd_T[g] : '0;
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Walk bookkeeping: capture on an accepted request, step down while walking.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr    <= '0;
            r_rem    <= '0;
            r_branch <= '0;
        end else if (w_start) begin
            r_ptr    <= w_ptr_init;
            r_rem    <= w_rem_init;
            r_branch <= branch_idx;
        end else if (r_state == WALK) begin
            r_ptr <= w_ptr_step;
            r_rem <= w_rem_step;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Next-state logic; requests outside IDLE are dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (mispredict_valid) begin
                    if (w_rem_init != '0) begin
                        w_state_nxt = WALK;
                    end else begin
                        w_state_nxt = FIN;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WALK: begin
                if (w_rem_step == '0) begin
                    w_state_nxt = FIN;
                end else begin
                    w_state_nxt = WALK;
                end
            end
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode into the walker side of the rewind bundle.
    always_comb begin
        u_rw_if.num      = NUM_W'(w_n);
        u_rw_if.reg_T    = w_reg_T;
        u_rw_if.busy     = (r_state != IDLE);
        u_rw_if.done     = 1'b0;
        u_rw_if.new_tail = '0;
        if (r_state == FIN) begin
            u_rw_if.done     = 1'b1;
            u_rw_if.new_tail = r_branch + IDX_ONE;
        end else begin
            u_rw_if.done     = 1'b0;
            u_rw_if.new_tail = '0;
        end
    end

    assign rewind_num   = u_rw_if.num;
    assign rewind_reg_T = u_rw_if.reg_T;
    assign busy         = u_rw_if.busy;
    assign done         = u_rw_if.done;
    assign new_tail     = u_rw_if.new_tail;
endmodule

// File: doc/rewind_walker.md
REWIND_WALKER -- requirements
Module: rewind_walker

Interface
REQ-001 The module SHALL have parameter WAY, default 3: maximum squashed ROB entries emitted per cycle.
REQ-002 The module SHALL have parameter ROB_SIZE, default 32: ROB depth, a power of two; index width is log2(ROB_SIZE).
REQ-003 The module SHALL have parameter PR_W, default 6: physical register index width.
REQ-004 The module SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 The module SHALL have port mispredict_valid, input, 1: pulse requesting a rewind.
REQ-007 The module SHALL have port branch_idx, input, log2(ROB_SIZE): ROB index of the mispredicted branch.
REQ-008 The module SHALL have port rob_tail, input, log2(ROB_SIZE): ROB next-free index at request time.
REQ-009 The module SHALL have port rob_rd_idx, output, WAY x log2(ROB_SIZE): combinational ROB read addresses.
REQ-010 The module SHALL have port rob_rd_T, input, WAY x PR_W: same-cycle ROB read data giving T per read port.
REQ-011 The module SHALL have port rewind_num, output, log2(WAY)+1: number of valid slots this cycle; 0 = no rewind activity.
REQ-012 The module SHALL have port rewind_reg_T, output, WAY x PR_W: T values returned to the freelist; 0 = entry had no destination.
REQ-013 The module SHALL have port busy, output, 1: walk in progress; the source must not assert mispredict_valid while busy is high.
REQ-014 The module SHALL have port done, output, 1: one-cycle pulse at walk completion.
REQ-015 The module SHALL have port new_tail, output, log2(ROB_SIZE): equals branch_idx+1 mod ROB_SIZE and is valid while done is high.

Function
REQ-016 The FSM SHALL have three states: IDLE, WALK and FIN.
REQ-017 In IDLE, mispredict_valid SHALL capture branch_idx, set ptr = rob_tail-1 mod ROB_SIZE, set remaining = (rob_tail-branch_idx-1) mod ROB_SIZE, and go to WALK if remaining>0, otherwise to FIN.
REQ-018 In WALK, n = min(WAY, remaining) SHALL apply: rewind_num = n; slot i (i<n) reads ROB entry ptr-(n-1-i) mod ROB_SIZE, so slot 0 is the oldest entry of the group and slot n-1 the youngest.
REQ-019 In WALK, rewind_reg_T[i] = rob_rd_T[i] for i<n and 0 for i>=n; rob_rd_idx for unused slots SHALL be 0.
REQ-020 Each WALK cycle SHALL update ptr -= n mod ROB_SIZE and remaining -= n; the FSM SHALL move to FIN when remaining reaches 0.
REQ-021 In FIN, done = 1 and new_tail = branch_idx+1 mod ROB_SIZE, then the FSM SHALL return to IDLE.
REQ-022 busy SHALL be high in WALK and FIN and low in IDLE; rewind_num SHALL be 0 outside WALK.
REQ-023 Latency: for a request in cycle N, the walk SHALL occupy cycles N+1 .. N+ceil(remaining/WAY), and done SHALL follow in the next cycle.
REQ-024 mispredict_valid while busy SHALL be ignored, with no state change.
REQ-025 All ROB index arithmetic SHALL wrap modulo ROB_SIZE.
REQ-026 With a full ROB and branch oldest (rob_tail == branch_idx), remaining SHALL equal ROB_SIZE-1.

Reset
REQ-027 Reset SHALL force IDLE, ptr = 0, remaining = 0, branch register = 0, busy = 0, done = 0, rewind_num = 0, all rewind_reg_T = 0 and new_tail = 0.
REQ-028 Reset asserted mid-walk SHALL abort immediately with no done pulse; outputs SHALL be 0 in the next cycle after deassertion.

Structure
REQ-029 rob_idx_t, phy_reg_idx_t, `WAY and `ROB_SIZE SHALL come from the shared rewind/ROB header, not be redefined locally.
REQ-030 Modular index subtraction SHALL be one sub-module, rob_idx_sub, instantiated for the count computation and the per-slot addresses.
REQ-031 The rewind outputs SHALL be exposed through the rewind interface's walker modport.

Verification
REQ-032 branch=5, tail=6 -> no WALK cycles; done at N+1 with new_tail=6; rewind_num stays 0.
REQ-033 branch=5, tail=10 (4 entries) -> cycle N+1: num=3 reading 7,8,9; N+2: num=1 reading 6; done at N+3 with new_tail=6.
REQ-034 branch=30, tail=2 (wrap; 3 entries) -> N+1: num=3 reading 31,0,1; done at N+2 with new_tail=31.
REQ-035 branch=4, tail=4 (full ROB) -> remaining=31; 11 WALK cycles (10x3 + 1x1); done at N+12.
REQ-036 ROB entry with T=0 inside the walk -> that slot rewind_reg_T=0, other slots correct, num unchanged.
REQ-037 Reset asserted at N+2 of a 9-entry walk -> no done pulse, all outputs 0; a new request after reset behaves normally.
